data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Responder end of the MEM-stage data-memory interface. Answers the read/write requests issued by the pipeline's MEM stage.
- Holds a word-addressed on-chip RAM and adds a configurable number of wait states.
- Raises a stall toward the hazard/control unit until each access completes.
- Returns read data on mem_din and flags illegal accesses.

Parameters:
- DEPTH, 1024: number of 32-bit words; must be a power of two.
- ADDR_W, 10: log2(DEPTH), the word-index width.
- WAIT_CYCLES, 2: extra access cycles per request; legal range 0..15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be DEPTH*4 aligned.

Ports:
- clk  input  1  main clock, rising edge
- rst  input  1  asynchronous active-high reset
- mem_ren  input  1  read request from MEM stage
- mem_wen  input  1  write request from MEM stage
- mem_addr  input  32  byte address (ALU result of MEM stage)
- mem_dout  input  32  write data from CPU
- mem_en  input  1  MEM stage enable; 1 = pipeline advances past MEM at this edge
- flush  input  1  MEM stage reset/flush; aborts the request in flight
- mem_din  output  32  read data to CPU
- mem_stall  output  1  1 = access not complete, control must hold the MEM stage
- mem_err  output  1  sticky illegal-access flag

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high.
- Reset: state=IDLE, cnt=0, rdata=0, mem_din=0, mem_stall=0, mem_err=0. RAM contents are not cleared and are retained across reset.
- req = mem_ren | mem_wen.
- Address decode:
  - off = mem_addr - BASE_ADDR (32-bit, wrap ignored).
  - idx = off[ADDR_W+1:2].
  - legal = (off[1:0]==0) & (off < DEPTH*4) & ~(mem_ren & mem_wen).
- IDLE:
  - mem_stall = req, combinational from the inputs.
  - If req & ~flush: cnt <= WAIT_CYCLES; latch ren, wen, idx, dout, legal; go to BUSY.
  - Otherwise stay IDLE.
- BUSY:
  - mem_stall=1.
  - If cnt!=0: cnt <= cnt-1.
  - If cnt==0, perform the access and go to DONE:
    - legal write: RAM[idx] <= dout.
    - legal read: rdata <= RAM[idx].
    - illegal: no RAM change, rdata <= 0, mem_err <= 1.
  - BUSY therefore lasts WAIT_CYCLES+1 cycles.
- DONE:
  - mem_stall=0; mem_din = rdata. rdata is held stable in DONE and afterwards until the next completed read.
  - If mem_en=1: go to IDLE.
  - If mem_en=0 (pipeline held by another hazard): stay in DONE with no repeat access.
- Latency: request visible at cycle t0 → mem_stall high for cycles t0..t0+WAIT_CYCLES+1 → DONE at t0+WAIT_CYCLES+2. With WAIT_CYCLES=0, stall is 2 cycles.
- Request stability: the CPU holds mem_ren, mem_wen, mem_addr and mem_dout stable while mem_stall=1. The block uses only the values latched in IDLE.
- flush:
  - In IDLE: blocks acceptance.
  - In BUSY: abort to IDLE, no RAM write, rdata unchanged, mem_err unchanged.
  - Same cycle as the BUSY cnt==0 edge: flush wins and the access is not performed.
  - In DONE: go to IDLE.
- mem_err is sticky; only rst clears it.
- Back-to-back: a new request seen in the IDLE cycle right after DONE starts a fresh transaction. No request is lost or merged.
- Reset mid-operation: immediate return to IDLE with outputs at reset values. A pending write is not committed.

Test Plan:
- WAIT_CYCLES=2, write 0xDEADBEEF to 0x10, mem_en=1 → mem_stall=1 for 4 cycles, DONE on cycle 4, RAM[4]=0xDEADBEEF; then read 0x10 → mem_din=0xDEADBEEF in DONE, 4 stall cycles.
- WAIT_CYCLES=0, back-to-back read 0x0 then read 0x4 (RAM preloaded 0x11, 0x22) → stall 2 cycles each, mem_din=0x11 then 0x22, 1 IDLE cycle between the two DONE states.
- Read 0x6 (misaligned), then write to DEPTH*4 (out of range), then ren=wen=1 → no RAM change, mem_din=0, mem_err=1 and it stays 1 until rst.
- Write 0x55 to 0x8 with flush asserted on the 2nd BUSY cycle → return to IDLE, RAM[2] unchanged, mem_err=0.
- Read completes with mem_en=0 for 3 cycles → stays DONE, mem_stall=0, mem_din stable, no extra access; goes to IDLE on the first mem_en=1 edge.
- Assert rst asynchronously mid-BUSY on a write → outputs immediately 0 and state IDLE, target word unchanged, previously written words retained.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// MEM-stage data-memory bus: the pipeline drives requests, the responder answers with data, stall and error.
// The master modport is the CPU side and the slave modport is the memory side.
interface data_mem_responder_if;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic        mem_en;
  logic        flush;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        mem_err;

  modport master (
    output mem_ren, mem_wen, mem_addr, mem_dout, mem_en, flush,
    input  mem_din, mem_stall, mem_err
  );

  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_dout, mem_en, flush,
    output mem_din, mem_stall, mem_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM behind the MEM stage; each access takes WAIT_CYCLES+2 stalled cycles before DONE.
// Stall is the only backpressure: it holds the MEM stage until DONE, and DONE waits for mem_en before returning to IDLE.
module data_mem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                ren_q, ren_d;
  logic                wen_q, wen_d;
  logic                legal_q, legal_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         dout_q, dout_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [31:0]         ram [DEPTH];
  logic                ram_we;

  logic                req;
  logic [31:0]         off;
  logic [ADDR_W-1:0]   idx;
  logic                legal;
  logic                accept;
  logic                access_now;

  assign req    = bus.mem_ren | bus.mem_wen;
  assign off    = bus.mem_addr - BASE_ADDR;
  assign idx    = off[ADDR_W+1:2];
  // Range check is on the high offset bits so it also catches addresses below BASE_ADDR (they wrap high).
  assign legal  = (off[1:0] == 2'b00) && (off[31:ADDR_W+2] == '0) && !(bus.mem_ren && bus.mem_wen);
  assign accept = (state_q == IDLE) && req && !bus.flush;
  // Flush on the final BUSY edge cancels the access outright.
  assign access_now = (state_q == BUSY) && !bus.flush && (cnt_q == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      legal_q <= 1'b0;
      idx_q   <= '0;
      dout_q  <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      legal_q <= legal_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[idx_q] <= dout_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req && !bus.flush) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.flush || bus.mem_en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    legal_d = legal_q;
    idx_d   = idx_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ram_we  = 1'b0;

    if (accept) begin
      cnt_d   = 4'(WAIT_CYCLES);
      ren_d   = bus.mem_ren;
      wen_d   = bus.mem_wen;
      legal_d = legal;
      idx_d   = idx;
      dout_d  = bus.mem_dout;
    end

    if ((state_q == BUSY) && !bus.flush && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end

    if (access_now) begin
      if (!legal_q) begin
        rdata_d = 32'd0;
        err_d   = 1'b1;
      end else if (wen_q) begin
        ram_we = 1'b1;
      end else if (ren_q) begin
        rdata_d = ram[idx_q];
      end
    end
  end

  // Stall is forced low during reset so outputs read as reset values even with a request held.
  always_comb begin
    bus.mem_stall = 1'b0;
    case (state_q)
      IDLE:    bus.mem_stall = req;
      BUSY:    bus.mem_stall = 1'b1;
      default: bus.mem_stall = 1'b0;
    endcase
    bus.mem_stall = bus.mem_stall & ~rst;
    bus.mem_din   = rdata_q;
    bus.mem_err   = err_q;
  end

endmodule
